e_mdu: RTL

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It holds the HI/LO register pair and runs multi-cycle mult/multu/div/divu. It serves mfhi/mflo/mthi/mtlo. It drives `real_busy`, which the D-stage stall controller combines with the D-stage MDU opcode to hold back any MDU instruction while an operation is in flight. It sits beside the ALU in E. Its read output feeds the E/M pipeline register through the E-stage result mux.

---
 rtl/e_mdu.sv | 126 ++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO and runs multi-cycle mult/multu/div/divu.
// The result is computed when the operation starts and held back until the modelled latency has elapsed.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  MDU_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        start,
   output logic        busy,
   output logic        real_busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDU_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [4:0] OP_MULT  = 5'd1;
   localparam logic [4:0] OP_MULTU = 5'd2;
   localparam logic [4:0] OP_DIV   = 5'd3;
   localparam logic [4:0] OP_DIVU  = 5'd4;
   localparam logic [4:0] OP_MFHI  = 5'd5;
   localparam logic [4:0] OP_MFLO  = 5'd6;
   localparam logic [4:0] OP_MTHI  = 5'd7;
   localparam logic [4:0] OP_MTLO  = 5'd8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        hi_tmp;
   logic [31:0]        lo_tmp;
   logic               is_arith;
   logic               is_div;
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        res_hi;
   logic [31:0]        res_lo;

   assign is_arith  = (MDU_op >= OP_MULT) && (MDU_op <= OP_DIVU);
   assign is_div    = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
   assign busy      = (state == RUN);
   assign start     = is_arith && !busy;
   assign real_busy = start || busy;

   assign MDU_out = (MDU_op == OP_MFHI) ? HI :
                    (MDU_op == OP_MFLO) ? LO : 32'd0;

   // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // A divide by zero latches the current HI/LO so the later commit leaves them unchanged.
   always_comb begin
      res_hi = HI;
      res_lo = LO;
      case (MDU_op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            if (B != 32'd0) begin
               if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                  res_lo = 32'h8000_0000;
                  res_hi = 32'd0;
               end else begin
                  res_lo = 32'($signed(A) / $signed(B));
                  res_hi = 32'($signed(A) % $signed(B));
               end
            end
         end
         OP_DIVU: begin
            if (B != 32'd0) begin
               res_lo = A / B;
               res_hi = A % B;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  cnt    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  hi_tmp <= res_hi;
                  lo_tmp <= res_lo;
               end else if (MDU_op == OP_MTHI) begin
                  HI <= A;
               end else if (MDU_op == OP_MTLO) begin
                  LO <= A;
               end
            end
            RUN: begin
               if (cnt == CNT_W'(1)) begin
                  state <= IDLE;
                  cnt   <= '0;
                  HI    <= hi_tmp;
                  LO    <= lo_tmp;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
